// File: rtl/uart_decimal_tx.sv
// rtl/uart_decimal_tx.sv - prints a 16-bit unsigned value as decimal ASCII over an 8N1 UART line
module uart_decimal_tx #(
    parameter int CLKS_PER_BIT = 347,
    parameter int APPEND_CRLF  = 1
) (
    input  logic        clock,
    input  logic        resetb,
    input  logic [15:0] value_i,
    input  logic        valid_i,
    output logic        ready_o,
    output logic        tx_o,
    output logic        frame_done_o,
    output logic        msg_done_o
);

    localparam int CW = $clog2(CLKS_PER_BIT);
    localparam logic [CW-1:0] LAST_CNT = CW'(CLKS_PER_BIT - 1);
    localparam logic [CW-1:0] PRE_LAST_CNT = CW'(CLKS_PER_BIT - 2);
    localparam logic [2:0] CRLF_CHARS = (APPEND_CRLF != 0) ? 3'd2 : 3'd0;

    typedef enum logic [1:0] {
        IDLE,
        CONVERT,
        LOAD,
        SEND
    } state_t;

    state_t state, state_nxt;

    logic [15:0]   bin_sr;
    logic [19:0]   bcd;
    logic [19:0]   bcd_adj;
    logic [3:0]    conv_cnt;
    logic [CW-1:0] bit_cnt;
    logic [3:0]    bit_idx;
    logic [8:0]    frame_sr;
    logic [2:0]    char_idx;
    logic          tx_q;
    logic          frame_done_q;
    logic          msg_done_q;

    logic [2:0]    num_digits;
    logic [2:0]    num_chars;
    logic [2:0]    digit_pos;
    logic [3:0]    digit;
    logic [7:0]    char_byte;
    logic          last_char;
    logic          bit_end;
    logic          stop_pre_end;

    // Double-dabble correction applied before each left shift.
    always_comb begin
        bcd_adj = bcd;
        for (int d = 0; d < 5; d++) begin
            if (bcd[4*d +: 4] >= 4'd5) begin
                bcd_adj[4*d +: 4] = bcd[4*d +: 4] + 4'd3;
            end
        end
    end

    always_comb begin
        num_digits = 3'd1;
        if (bcd[19:16] != 4'd0) begin
            num_digits = 3'd5;
        end else if (bcd[15:12] != 4'd0) begin
            num_digits = 3'd4;
        end else if (bcd[11:8] != 4'd0) begin
            num_digits = 3'd3;
        end else if (bcd[7:4] != 4'd0) begin
            num_digits = 3'd2;
        end
    end

    // Printable digits are numbered from the most significant nonzero one.
    always_comb begin
        num_chars = num_digits + CRLF_CHARS;
        digit_pos = num_digits - 3'd1 - char_idx;
        case (digit_pos)
            3'd0:    digit = bcd[3:0];
            3'd1:    digit = bcd[7:4];
            3'd2:    digit = bcd[11:8];
            3'd3:    digit = bcd[15:12];
            3'd4:    digit = bcd[19:16];
            default: digit = 4'd0;
        endcase
        if (char_idx < num_digits) begin
            char_byte = {4'h3, digit};
        end else if (char_idx == num_digits) begin
            char_byte = 8'h0D;
        end else begin
            char_byte = 8'h0A;
        end
        last_char    = (char_idx == num_chars - 3'd1);
        bit_end      = (bit_cnt == LAST_CNT);
        stop_pre_end = (bit_idx == 4'd9) && (bit_cnt == PRE_LAST_CNT);
    end

    always_ff @(posedge clock or negedge resetb) begin
        if (!resetb) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    // LOAD for every character after the first occupies the final stop-bit cycle,
    // so frames run back to back.
    always_comb begin
        state_nxt = state;
        case (state)
            IDLE: begin
                if (valid_i) begin
                    state_nxt = CONVERT;
                end
            end
            CONVERT: begin
                if (conv_cnt == 4'd15) begin
                    state_nxt = LOAD;
                end
            end
            LOAD: begin
                state_nxt = SEND;
            end
            SEND: begin
                if (stop_pre_end && !last_char) begin
                    state_nxt = LOAD;
                end else if ((bit_idx == 4'd9) && bit_end) begin
                    state_nxt = IDLE;
                end
            end
            default: begin
                state_nxt = IDLE;
            end
        endcase
    end

    always_ff @(posedge clock or negedge resetb) begin
        if (!resetb) begin
            bin_sr       <= '0;
            bcd          <= '0;
            conv_cnt     <= '0;
            bit_cnt      <= '0;
            bit_idx      <= '0;
            frame_sr     <= '1;
            char_idx     <= '0;
            tx_q         <= 1'b1;
            frame_done_q <= 1'b0;
            msg_done_q   <= 1'b0;
        end else begin
            frame_done_q <= 1'b0;
            msg_done_q   <= 1'b0;
            case (state)
                IDLE: begin
                    tx_q <= 1'b1;
                    if (valid_i) begin
                        bin_sr   <= value_i;
                        bcd      <= '0;
                        conv_cnt <= '0;
                        char_idx <= '0;
                    end
                end
                CONVERT: begin
                    {bcd, bin_sr} <= {bcd_adj, bin_sr} << 1;
                    conv_cnt      <= conv_cnt + 4'd1;
                end
                LOAD: begin
                    tx_q     <= 1'b0;
                    frame_sr <= {1'b1, char_byte};
                    bit_cnt  <= '0;
                    bit_idx  <= '0;
                end
                SEND: begin
                    if (bit_end) begin
                        bit_cnt  <= '0;
                        bit_idx  <= bit_idx + 4'd1;
                        tx_q     <= frame_sr[0];
                        frame_sr <= {1'b1, frame_sr[8:1]};
                    end else begin
                        bit_cnt <= bit_cnt + 1'b1;
                    end
                    if (stop_pre_end) begin
                        frame_done_q <= 1'b1;
                        msg_done_q   <= last_char;
                        if (!last_char) begin
                            char_idx <= char_idx + 3'd1;
                        end
                    end
                end
                default: begin
                    tx_q <= 1'b1;
                end
            endcase
        end
    end

    assign ready_o      = (state == IDLE);
    assign tx_o         = tx_q;
    assign frame_done_o = frame_done_q;
    assign msg_done_o   = msg_done_q;

endmodule

// File: tb/tb_uart_decimal_tx.sv
// tb/tb_uart_decimal_tx.sv - self-checking bench for uart_decimal_tx
module tb_uart_decimal_tx;

    localparam int C = 4;

    logic        clock = 1'b0;
    logic        resetb;
    logic [15:0] value_a, value_b;
    logic        valid_a, valid_b;
    logic        ready_a, tx_a, fd_a, md_a;
    logic        ready_b, tx_b, fd_b, md_b;

    int checks   = 0;
    int failures = 0;

    logic [7:0] exp_q[$];
    logic       tr_tx [0:511];
    logic       tr_fd [0:511];
    logic       tr_md [0:511];
    logic       tr_rdy[0:511];

    always #5 clock = ~clock;

    uart_decimal_tx #(.CLKS_PER_BIT(C), .APPEND_CRLF(1)) dut_a (
        .clock(clock), .resetb(resetb), .value_i(value_a), .valid_i(valid_a),
        .ready_o(ready_a), .tx_o(tx_a), .frame_done_o(fd_a), .msg_done_o(md_a)
    );

    uart_decimal_tx #(.CLKS_PER_BIT(C), .APPEND_CRLF(0)) dut_b (
        .clock(clock), .resetb(resetb), .value_i(value_b), .valid_i(valid_b),
        .ready_o(ready_b), .tx_o(tx_b), .frame_done_o(fd_b), .msg_done_o(md_b)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    function automatic void model(input int v, input bit crlf);
        string s;
        exp_q.delete();
        s = $sformatf("%0d", v);
        for (int i = 0; i < s.len(); i++) exp_q.push_back(8'(s[i]));
        if (crlf) begin
            exp_q.push_back(8'h0D);
            exp_q.push_back(8'h0A);
        end
    endfunction

    // k = number of rising edges after the accepting edge.
    function automatic logic exp_tx_at(input int k);
        int j, f, p, b;
        if (k < 17) return 1'b1;
        j = k - 17;
        f = j / (10 * C);
        if (f >= exp_q.size()) return 1'b1;
        p = j % (10 * C);
        b = p / C;
        if (b == 0) return 1'b0;
        if (b == 9) return 1'b1;
        return exp_q[f][b-1];
    endfunction

    task automatic run_msg(input bit sel, input logic [15:0] v, input bit inject, input string tag);
        int n, total, e_tx, e_fd, e_md, e_rdy, n_fd, n_md, rdy_pos;
        logic [7:0] got;
        model(int'(v), !sel);
        n     = exp_q.size();
        total = 17 + 10 * C * n;
        @(negedge clock);
        if (sel) begin value_b = v; valid_b = 1'b1; end
        else     begin value_a = v; valid_a = 1'b1; end
        chk({tag, ":ready_before"}, sel ? ready_b : ready_a, 1);
        for (int k = 0; k <= total + 3; k++) begin
            if (k > 0) @(posedge clock);
            else       @(posedge clock);
            #1;
            if (k == 0) begin
                valid_a = 1'b0; valid_b = 1'b0;
                value_a = 16'($urandom); value_b = 16'($urandom);
            end
            if (inject && k == 40) begin
                if (sel) begin value_b = 16'd7; valid_b = 1'b1; end
                else     begin value_a = 16'd7; valid_a = 1'b1; end
            end
            if (inject && k == total - 5) begin
                valid_a = 1'b0; valid_b = 1'b0;
            end
            tr_tx[k]  = sel ? tx_b : tx_a;
            tr_fd[k]  = sel ? fd_b : fd_a;
            tr_md[k]  = sel ? md_b : md_a;
            tr_rdy[k] = sel ? ready_b : ready_a;
        end
        e_tx = 0; e_fd = 0; e_md = 0; e_rdy = 0; n_fd = 0; n_md = 0; rdy_pos = -1;
        for (int k = 0; k <= total + 3; k++) begin
            int j;
            logic fd_exp;
            j = k - 17;
            fd_exp = (k >= 17) && (j / (10 * C) < n) && (j % (10 * C) == 10 * C - 1);
            if (tr_tx[k] !== exp_tx_at(k)) e_tx++;
            if (tr_fd[k] !== fd_exp) e_fd++;
            if (tr_md[k] !== (k == total - 1)) e_md++;
            if (tr_rdy[k] !== (k >= total)) e_rdy++;
            if (tr_fd[k] === 1'b1) n_fd++;
            if (tr_md[k] === 1'b1) n_md++;
            if (rdy_pos < 0 && tr_rdy[k] === 1'b1) rdy_pos = k;
        end
        chk({tag, ":tx_wave_errs"}, e_tx, 0);
        chk({tag, ":frame_done_errs"}, e_fd, 0);
        chk({tag, ":msg_done_errs"}, e_md, 0);
        chk({tag, ":ready_errs"}, e_rdy, 0);
        chk({tag, ":frame_done_count"}, n_fd, n);
        chk({tag, ":msg_done_count"}, n_md, 1);
        chk({tag, ":ready_cycle"}, rdy_pos, total);
        for (int f = 0; f < n; f++) begin
            for (int b = 0; b < 8; b++) got[b] = tr_tx[17 + f * 10 * C + (b + 1) * C + C / 2];
            chk($sformatf("%s:byte%0d", tag, f), got, exp_q[f]);
        end
    endtask

    initial begin
        int e_idle;
        logic [15:0] rv;
        resetb = 1'b0; valid_a = 1'b0; valid_b = 1'b0; value_a = '0; value_b = '0;
        repeat (3) @(posedge clock);
        #1;
        chk("reset:tx_a", tx_a, 1);
        chk("reset:ready_a", ready_a, 1);
        chk("reset:fd_a", fd_a, 0);
        chk("reset:md_a", md_a, 0);
        chk("reset:tx_b", tx_b, 1);
        chk("reset:ready_b", ready_b, 1);
        @(negedge clock);
        resetb = 1'b1;

        run_msg(1'b0, 16'd0, 1'b0, "v0");
        run_msg(1'b0, 16'd65535, 1'b0, "v65535");
        run_msg(1'b0, 16'd1000, 1'b0, "v1000");
        run_msg(1'b0, 16'd42, 1'b1, "v42_drop");
        run_msg(1'b1, 16'd5, 1'b0, "v5_nocrlf");

        for (int i = 0; i < 6; i++) begin
            case (i % 4)
                0: rv = 16'($urandom_range(0, 9));
                1: rv = 16'($urandom_range(10, 999));
                2: rv = 16'($urandom_range(1000, 9999));
                default: rv = 16'($urandom_range(10000, 65535));
            endcase
            run_msg(1'(i % 2), rv, 1'b0, $sformatf("rand%0d_%0d", i, rv));
        end

        // Abort value 123 during data bit 3 of its second character.
        model(123, 1'b1);
        @(negedge clock);
        value_a = 16'd123; valid_a = 1'b1;
        @(posedge clock);
        #1;
        valid_a = 1'b0;
        for (int k = 1; k <= 74; k++) begin
            @(posedge clock);
            #1;
        end
        chk("abort:tx_before", tx_a, exp_tx_at(74));
        #2;
        resetb = 1'b0;
        #1;
        chk("abort:tx", tx_a, 1);
        chk("abort:ready", ready_a, 1);
        chk("abort:md", md_a, 0);
        @(negedge clock);
        resetb = 1'b1;
        e_idle = 0;
        for (int k = 0; k < 120; k++) begin
            @(posedge clock);
            #1;
            if (tx_a !== 1'b1 || fd_a !== 1'b0 || md_a !== 1'b0 || ready_a !== 1'b1) e_idle++;
        end
        chk("abort:idle_errs", e_idle, 0);

        run_msg(1'b0, 16'($urandom_range(0, 65535)), 1'b0, "after_abort");

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
